// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ALEN = 32;
  localparam int unsigned ILEN = 32;
  localparam int unsigned XLEN = 64;
  localparam int unsigned BEW  = XLEN / 8;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LSU   = 1'b1
  } requester_t;

  typedef struct packed {
    requester_t owner;
    logic       word_sel;
    logic       discard;
  } arb_fifo_entry_t;

endpackage

// File: rtl/arb_order_fifo.sv
// In-order tracker of outstanding memory requests; fetch entries can be
// marked for discard in bulk when the fetch stage flushes.
module arb_order_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  arb_fifo_entry_t push_entry_i,
  input  logic            pop_i,
  input  logic            flush_mark_i,
  output logic            full_o,
  output logic            empty_o,
  output arb_fifo_entry_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  arb_fifo_entry_t  slots_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = slots_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Flush marks go to every fetch slot; a same-cycle push overwrites its own slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      if (flush_mark_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (slots_q[i].owner == REQ_FETCH) slots_q[i].discard <= 1'b1;
        end
      end
      if (do_push) begin
        slots_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit,
// routing in-order responses back to their owner.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            if_req_valid_i,
  output logic            if_req_ready_o,
  input  logic [ALEN-1:0] if_req_addr_i,
  output logic            if_rsp_valid_o,
  input  logic            if_rsp_ready_i,
  output logic [ILEN-1:0] if_rsp_instr_o,
  output logic            if_rsp_except_o,
  input  logic            ls_req_valid_i,
  output logic            ls_req_ready_o,
  input  logic            ls_req_we_i,
  input  logic [ALEN-1:0] ls_req_addr_i,
  input  logic [XLEN-1:0] ls_req_wdata_i,
  input  logic [BEW-1:0]  ls_req_be_i,
  output logic            ls_rsp_valid_o,
  input  logic            ls_rsp_ready_i,
  output logic [XLEN-1:0] ls_rsp_rdata_o,
  output logic            ls_rsp_except_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_req_we_o,
  output logic [ALEN-1:0] mem_req_addr_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  output logic [BEW-1:0]  mem_req_be_o,
  input  logic            mem_rsp_valid_i,
  output logic            mem_rsp_ready_o,
  input  logic [XLEN-1:0] mem_rsp_rdata_i,
  input  logic            mem_rsp_except_i
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_IF = 2'd1,
    LOCK_LS = 2'd2
  } lock_state_t;

  lock_state_t         state_q, state_d;
  logic [STREAK_W-1:0] streak_q;
  logic                streak_max;
  logic                grant_valid;
  requester_t          grant_owner;
  logic                mem_accept;
  logic                fifo_full, fifo_empty;
  arb_fifo_entry_t     head, push_entry;
  logic                pop;
  logic                fetch_drop;

  assign streak_max = (streak_q == STREAK_W'(MAX_DATA_STREAK));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Grant selection and lock tracking; an unaccepted fetch grant never locks across a flush.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_owner = REQ_LSU;
    unique case (state_q)
      IDLE: begin
        if (!fifo_full) begin
          if (ls_req_valid_i && !(streak_max && if_req_valid_i)) begin
            grant_valid = 1'b1;
            grant_owner = REQ_LSU;
          end else if (if_req_valid_i) begin
            grant_valid = 1'b1;
            grant_owner = REQ_FETCH;
          end
        end
      end
      LOCK_IF: begin
        grant_valid = 1'b1;
        grant_owner = REQ_FETCH;
      end
      LOCK_LS: begin
        grant_valid = 1'b1;
        grant_owner = REQ_LSU;
      end
      default: grant_valid = 1'b0;
    endcase
    mem_accept = grant_valid && mem_req_ready_i;
    if (grant_valid && !mem_req_ready_i && !(grant_owner == REQ_FETCH && flush_i)) begin
      state_d = (grant_owner == REQ_FETCH) ? LOCK_IF : LOCK_LS;
    end else begin
      state_d = IDLE;
    end
  end

  always_comb begin
    mem_req_valid_o = grant_valid;
    if_req_ready_o  = mem_accept && (grant_owner == REQ_FETCH);
    ls_req_ready_o  = mem_accept && (grant_owner == REQ_LSU);
    if (grant_owner == REQ_FETCH) begin
      mem_req_we_o    = 1'b0;
      mem_req_addr_o  = if_req_addr_i;
      mem_req_wdata_o = '0;
      mem_req_be_o    = '0;
    end else begin
      mem_req_we_o    = ls_req_we_i;
      mem_req_addr_o  = ls_req_addr_i;
      mem_req_wdata_o = ls_req_wdata_i;
      mem_req_be_o    = ls_req_be_i;
    end
    push_entry.owner    = grant_owner;
    push_entry.word_sel = mem_req_addr_o[2];
    push_entry.discard  = (grant_owner == REQ_FETCH) && flush_i;
  end

  // Data streak only grows while a fetch is actually waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q <= '0;
    end else if (if_req_ready_o || !if_req_valid_i) begin
      streak_q <= '0;
    end else if (ls_req_ready_o && !streak_max) begin
      streak_q <= streak_q + STREAK_W'(1);
    end
  end

  arb_order_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (mem_accept),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .flush_mark_i(flush_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // Response demux; a flushed fetch head is consumed without reaching fetch.
  always_comb begin
    fetch_drop      = head.discard || flush_i;
    if_rsp_valid_o  = 1'b0;
    ls_rsp_valid_o  = 1'b0;
    mem_rsp_ready_o = 1'b0;
    if_rsp_instr_o  = head.word_sel ? mem_rsp_rdata_i[XLEN-1 -: ILEN] : mem_rsp_rdata_i[ILEN-1:0];
    if_rsp_except_o = mem_rsp_except_i;
    ls_rsp_rdata_o  = mem_rsp_rdata_i;
    ls_rsp_except_o = mem_rsp_except_i;
    if (!fifo_empty) begin
      if (head.owner == REQ_FETCH) begin
        if_rsp_valid_o  = mem_rsp_valid_i && !fetch_drop;
        mem_rsp_ready_o = fetch_drop || if_rsp_ready_i;
      end else begin
        ls_rsp_valid_o  = mem_rsp_valid_i;
        mem_rsp_ready_o = ls_rsp_ready_i;
      end
    end
  end

  assign pop = mem_rsp_valid_i && mem_rsp_ready_o;

  rsp_without_request: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(mem_rsp_valid_i && fifo_empty)
  ) else $error("memory response arrived with no outstanding request");

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_imem_dmem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned MAXO = 4;
  localparam int unsigned MAXS = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic flush_i;
  logic if_req_valid_i, if_req_ready_o;
  logic [ALEN-1:0] if_req_addr_i;
  logic if_rsp_valid_o, if_rsp_ready_i;
  logic [ILEN-1:0] if_rsp_instr_o;
  logic if_rsp_except_o;
  logic ls_req_valid_i, ls_req_ready_o, ls_req_we_i;
  logic [ALEN-1:0] ls_req_addr_i;
  logic [XLEN-1:0] ls_req_wdata_i;
  logic [BEW-1:0] ls_req_be_i;
  logic ls_rsp_valid_o, ls_rsp_ready_i;
  logic [XLEN-1:0] ls_rsp_rdata_o;
  logic ls_rsp_except_o;
  logic mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [ALEN-1:0] mem_req_addr_o;
  logic [XLEN-1:0] mem_req_wdata_o;
  logic [BEW-1:0] mem_req_be_o;
  logic mem_rsp_valid_i, mem_rsp_ready_o;
  logic [XLEN-1:0] mem_rsp_rdata_i;
  logic mem_rsp_except_i;

  imem_dmem_arbiter #(.MAX_OUTSTANDING(MAXO), .MAX_DATA_STREAK(MAXS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o), .if_req_addr_i(if_req_addr_i),
    .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_ready_i(if_rsp_ready_i), .if_rsp_instr_o(if_rsp_instr_o),
    .if_rsp_except_o(if_rsp_except_o),
    .ls_req_valid_i(ls_req_valid_i), .ls_req_ready_o(ls_req_ready_o), .ls_req_we_i(ls_req_we_i),
    .ls_req_addr_i(ls_req_addr_i), .ls_req_wdata_i(ls_req_wdata_i), .ls_req_be_i(ls_req_be_i),
    .ls_rsp_valid_o(ls_rsp_valid_o), .ls_rsp_ready_i(ls_rsp_ready_i), .ls_rsp_rdata_o(ls_rsp_rdata_o),
    .ls_rsp_except_o(ls_rsp_except_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_rdata_i(mem_rsp_rdata_i), .mem_rsp_except_i(mem_rsp_except_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: owner 1 = fetch, 2 = LSU, 0 = none.
  typedef struct {
    int unsigned owner;
    logic        ws;
    logic        disc;
    logic [63:0] rdata;
    logic        exc;
  } txn_t;

  txn_t        q[$];
  int unsigned lock_own = 0;
  int unsigned streak = 0;
  logic [63:0] nxt_rdata = 64'h0123_4567_89ab_cdef;
  logic        nxt_exc = 1'b0;
  logic        rsp_want = 1'b0;
  logic        acc_if, acc_ls;
  logic        obs_if_rdy, obs_ls_rdy, obs_ifv, obs_lsv, obs_mrr, obs_lsexc;
  logic [31:0] obs_maddr, obs_instr;
  logic [63:0] obs_rdata;

  task automatic clear_inputs();
    flush_i = 1'b0; if_req_valid_i = 1'b0; if_req_addr_i = '0; if_rsp_ready_i = 1'b0;
    ls_req_valid_i = 1'b0; ls_req_we_i = 1'b0; ls_req_addr_i = '0; ls_req_wdata_i = '0;
    ls_req_be_i = '0; ls_rsp_ready_i = 1'b0; mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = '0; mem_rsp_except_i = 1'b0; rsp_want = 1'b0;
  endtask

  // One clock cycle: memory drives the head response, outputs checked mid-cycle, model advanced.
  task automatic step();
    int unsigned g;
    logic e_ifv, e_lsv, e_mrr, drop, pop, fl;
    txn_t t;
    mem_rsp_valid_i = rsp_want && (q.size() > 0);
    if (q.size() > 0) begin
      mem_rsp_rdata_i  = q[0].rdata;
      mem_rsp_except_i = q[0].exc;
    end else begin
      mem_rsp_rdata_i  = {$urandom, $urandom};
      mem_rsp_except_i = 1'b0;
    end
    #4;
    g = 0;
    if (lock_own != 0) g = lock_own;
    else if (q.size() < MAXO) begin
      if (ls_req_valid_i && !(streak == MAXS && if_req_valid_i)) g = 2;
      else if (if_req_valid_i) g = 1;
    end
    chk("mem_req_valid", 64'(mem_req_valid_o), 64'(g != 0));
    chk("if_req_ready", 64'(if_req_ready_o), 64'(g == 1 && mem_req_ready_i));
    chk("ls_req_ready", 64'(ls_req_ready_o), 64'(g == 2 && mem_req_ready_i));
    if (g == 1) begin
      chk("mem_addr_if", 64'(mem_req_addr_o), 64'(if_req_addr_i));
      chk("mem_we_if", 64'(mem_req_we_o), 64'(0));
    end
    if (g == 2) begin
      chk("mem_addr_ls", 64'(mem_req_addr_o), 64'(ls_req_addr_i));
      chk("mem_we_ls", 64'(mem_req_we_o), 64'(ls_req_we_i));
      if (ls_req_we_i) begin
        chk("mem_wdata", mem_req_wdata_o, ls_req_wdata_i);
        chk("mem_be", 64'(mem_req_be_o), 64'(ls_req_be_i));
      end
    end
    e_ifv = 1'b0; e_lsv = 1'b0; e_mrr = 1'b0;
    if (q.size() > 0) begin
      if (q[0].owner == 1) begin
        drop  = q[0].disc || flush_i;
        e_ifv = mem_rsp_valid_i && !drop;
        e_mrr = drop || if_rsp_ready_i;
      end else begin
        e_lsv = mem_rsp_valid_i;
        e_mrr = ls_rsp_ready_i;
      end
    end
    chk("if_rsp_valid", 64'(if_rsp_valid_o), 64'(e_ifv));
    chk("ls_rsp_valid", 64'(ls_rsp_valid_o), 64'(e_lsv));
    chk("mem_rsp_ready", 64'(mem_rsp_ready_o), 64'(e_mrr));
    if (e_ifv) begin
      chk("if_instr", 64'(if_rsp_instr_o), 64'(q[0].ws ? q[0].rdata[63:32] : q[0].rdata[31:0]));
      chk("if_except", 64'(if_rsp_except_o), 64'(q[0].exc));
    end
    if (e_lsv) begin
      chk("ls_rdata", ls_rsp_rdata_o, q[0].rdata);
      chk("ls_except", 64'(ls_rsp_except_o), 64'(q[0].exc));
    end
    obs_if_rdy = if_req_ready_o; obs_ls_rdy = ls_req_ready_o; obs_ifv = if_rsp_valid_o;
    obs_lsv = ls_rsp_valid_o; obs_mrr = mem_rsp_ready_o; obs_lsexc = ls_rsp_except_o;
    obs_maddr = mem_req_addr_o; obs_instr = if_rsp_instr_o; obs_rdata = ls_rsp_rdata_o;
    acc_if = (g == 1) && mem_req_ready_i;
    acc_ls = (g == 2) && mem_req_ready_i;
    pop = mem_rsp_valid_i && e_mrr;
    fl = flush_i;
    t.owner = g;
    t.ws    = (g == 1) ? if_req_addr_i[2] : ls_req_addr_i[2];
    t.disc  = (g == 1) && fl;
    t.rdata = nxt_rdata;
    t.exc   = nxt_exc;
    @(posedge clk_i);
    #1;
    if (fl) foreach (q[i]) if (q[i].owner == 1) q[i].disc = 1'b1;
    if (pop) void'(q.pop_front());
    if (acc_if || acc_ls) begin
      q.push_back(t);
      nxt_rdata = {$urandom, $urandom};
      nxt_exc   = ($urandom_range(7) == 0);
    end
    if (g != 0 && !mem_req_ready_i && !(g == 1 && fl)) lock_own = g;
    else lock_own = 0;
    if (acc_if || !if_req_valid_i) streak = 0;
    else if (acc_ls && streak < MAXS) streak++;
  endtask

  task automatic drain();
    clear_inputs();
    rsp_want = 1'b1; if_rsp_ready_i = 1'b1; ls_rsp_ready_i = 1'b1; mem_req_ready_i = 1'b1;
    for (int n = 0; n < 64 && q.size() > 0; n++) step();
    chk("drain_done", 64'(q.size()), 64'(0));
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] pat;
    logic ip, lp;
    clear_inputs();
    rst_ni = 1'b0;
    #12;
    chk("rst_mem_req_valid", 64'(mem_req_valid_o), 64'(0));
    chk("rst_if_req_ready", 64'(if_req_ready_o), 64'(0));
    chk("rst_ls_req_ready", 64'(ls_req_ready_o), 64'(0));
    chk("rst_if_rsp_valid", 64'(if_rsp_valid_o), 64'(0));
    chk("rst_ls_rsp_valid", 64'(ls_rsp_valid_o), 64'(0));
    chk("rst_mem_rsp_ready", 64'(mem_rsp_ready_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Both requesters busy: data streak of four, then one fetch.
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h100;
    ls_req_valid_i = 1'b1; ls_req_addr_i = 32'h800;
    mem_req_ready_i = 1'b1; rsp_want = 1'b1; if_rsp_ready_i = 1'b1; ls_rsp_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      pat[i] = obs_if_rdy;
    end
    chk("grant_pattern", 64'(pat), 64'(10'b10_0001_0000));
    drain();

    // Stalled fetch grant stays locked while data shows up.
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h2000;
    step();
    ls_req_valid_i = 1'b1; ls_req_addr_i = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_hold_addr", 64'(obs_maddr), 64'(32'h2000));
    end
    mem_req_ready_i = 1'b1;
    step();
    chk("lock_if_accept", 64'(obs_if_rdy), 64'(1));
    if_req_valid_i = 1'b0;
    step();
    chk("after_lock_ls_accept", 64'(obs_ls_rdy), 64'(1));
    drain();

    // Fill to MAX_OUTSTANDING with fetches.
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h400; mem_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ls_req_valid_i = 1'b1; ls_req_addr_i = 32'h500;
    step();
    chk("full_if_ready", 64'(obs_if_rdy), 64'(0));
    chk("full_ls_ready", 64'(obs_ls_rdy), 64'(0));
    rsp_want = 1'b1; if_rsp_ready_i = 1'b1;
    step();
    chk("full_pop_ready", 64'(obs_mrr), 64'(1));
    chk("full_pop_ls_ready", 64'(obs_ls_rdy), 64'(0));
    rsp_want = 1'b0;
    step();
    chk("rdy_after_pop", 64'(obs_ls_rdy), 64'(1));
    drain();

    // Flush with two fetches and one load outstanding.
    if_req_valid_i = 1'b1; mem_req_ready_i = 1'b1; if_req_addr_i = 32'h100;
    step();
    if_req_addr_i = 32'h104;
    step();
    if_req_valid_i = 1'b0; ls_req_valid_i = 1'b1; ls_req_addr_i = 32'h200;
    nxt_rdata = 64'h1122_3344_5566_7788; nxt_exc = 1'b0;
    step();
    ls_req_valid_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; rsp_want = 1'b1; if_rsp_ready_i = 1'b0; ls_rsp_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("flush_drop_ready", 64'(obs_mrr), 64'(1));
      chk("flush_drop_valid", 64'(obs_ifv), 64'(0));
    end
    step();
    chk("flush_ls_valid", 64'(obs_lsv), 64'(1));
    chk("flush_ls_rdata", obs_rdata, 64'h1122_3344_5566_7788);
    drain();

    // Upper instruction word selected by addr[2].
    nxt_rdata = 64'hAAAA_BBBB_CCCC_DDDD; nxt_exc = 1'b0;
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h1004; mem_req_ready_i = 1'b1;
    step();
    if_req_valid_i = 1'b0; rsp_want = 1'b1; if_rsp_ready_i = 1'b1;
    step();
    chk("instr_hi_valid", 64'(obs_ifv), 64'(1));
    chk("instr_hi", 64'(obs_instr), 64'(32'hAAAA_BBBB));
    drain();

    // Faulting data write.
    nxt_exc = 1'b1;
    ls_req_valid_i = 1'b1; ls_req_we_i = 1'b1; ls_req_addr_i = 32'h300;
    ls_req_wdata_i = 64'hdead_beef_0bad_f00d; ls_req_be_i = 8'hff; mem_req_ready_i = 1'b1;
    step();
    clear_inputs();
    rsp_want = 1'b1; ls_rsp_ready_i = 1'b1;
    step();
    chk("wr_fault_valid", 64'(obs_lsv), 64'(1));
    chk("wr_fault_except", 64'(obs_lsexc), 64'(1));
    chk("wr_fault_if_quiet", 64'(obs_ifv), 64'(0));
    drain();

    // Randomized traffic; requesters hold each request until accepted.
    ip = 1'b0; lp = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!ip && $urandom_range(1) == 1) begin
        ip = 1'b1;
        if_req_addr_i = $urandom & 32'hffff_fffc;
      end
      if (!lp && $urandom_range(1) == 1) begin
        lp = 1'b1;
        ls_req_we_i    = 1'($urandom_range(1));
        ls_req_addr_i  = $urandom;
        ls_req_wdata_i = {$urandom, $urandom};
        ls_req_be_i    = 8'($urandom);
      end
      if_req_valid_i  = ip;
      ls_req_valid_i  = lp;
      flush_i         = ($urandom_range(15) == 0);
      mem_req_ready_i = ($urandom_range(3) != 0);
      rsp_want        = ($urandom_range(2) != 0);
      if_rsp_ready_i  = 1'($urandom_range(1));
      ls_rsp_ready_i  = 1'($urandom_range(1));
      step();
      if (acc_if) ip = 1'b0;
      if (acc_ls) lp = 1'b0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
